// File: rtl/yc_pkg.sv
// Shared YC encoder types: line-timing FSM states, default timing and saturating counter helpers.
package yc_pkg;

    localparam int YC_PHASE_W      = 40;
    localparam int YC_CNT_W        = 12;
    localparam int YC_LINE_W       = 10;

    localparam int YC_BURST_START  = 60;
    localparam int YC_BURST_LEN    = 100;
    localparam int YC_ACTIVE_START = 240;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        BACK   = 3'd1,
        BURST  = 3'd2,
        GAP    = 3'd3,
        ACTIVE = 3'd4
    } yc_line_state_t;

    function automatic logic [YC_CNT_W-1:0] yc_cnt_inc(input logic [YC_CNT_W-1:0] v);
        return (v == {YC_CNT_W{1'b1}}) ? v : v + YC_CNT_W'(1);
    endfunction

    function automatic logic [YC_LINE_W-1:0] yc_line_inc(input logic [YC_LINE_W-1:0] v);
        return (v == {YC_LINE_W{1'b1}}) ? v : v + YC_LINE_W'(1);
    endfunction

endpackage

// File: rtl/yc_edge_detect.sv
// One-cycle-delay sampler with rise/fall detection against the delayed copy.
module yc_edge_detect (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_dly,
    output logic o_rise,
    output logic o_fall
);

    logic r_dly;

    // Previous-cycle sample; keeps tracking through reset so no false edge appears on release
    always_ff @(posedge i_clk) begin
        r_dly <= i_sig;
    end

    assign o_dly  = r_dly;
    assign o_rise = i_sig & ~r_dly;
    assign o_fall = ~i_sig & r_dly;

endmodule

// File: rtl/yc_line_sequencer.sv
// Line/field timing for the YC encoder: burst and active-chroma windows, PAL V-switch,
// and a field-latched subcarrier phase increment with accumulator clear.
module yc_line_sequencer
    import yc_pkg::*;
#(
    parameter int BURST_START  = YC_BURST_START,
    parameter int BURST_LEN    = YC_BURST_LEN,
    parameter int ACTIVE_START = YC_ACTIVE_START
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_pal_en,
    input  logic [YC_PHASE_W-1:0] i_phase_inc_ntsc,
    input  logic [YC_PHASE_W-1:0] i_phase_inc_pal,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    output logic [YC_PHASE_W-1:0] o_phase_inc,
    output logic                  o_std_pal,
    output logic                  o_burst_gate,
    output logic                  o_active_gate,
    output logic                  o_pal_flip,
    output logic                  o_accum_clr,
    output logic [YC_LINE_W-1:0]  o_line_num
);

    localparam logic [YC_CNT_W-1:0] C_BURST_ON  = YC_CNT_W'(BURST_START - 1);
    localparam logic [YC_CNT_W-1:0] C_BURST_OFF = YC_CNT_W'(BURST_START + BURST_LEN - 1);
    localparam logic [YC_CNT_W-1:0] C_ACT_ON    = YC_CNT_W'(ACTIVE_START - 1);

    if ((BURST_START < 1) || (BURST_LEN < 1) ||
        (ACTIVE_START <= BURST_START + BURST_LEN) || (ACTIVE_START > 4095)) begin : g_param_err
        $error("yc_line_sequencer: illegal BURST_START/BURST_LEN/ACTIVE_START combination");
    end

    logic                  w_hs_rise;
    logic                  w_hs_fall;
    logic                  w_hs_dly_unused;
    logic                  w_vs_rise;
    logic                  w_vs_fall_unused;
    logic                  w_vs_dly;
    logic [YC_PHASE_W-1:0] w_phase_sel;

    yc_line_state_t        r_state;
    logic [YC_CNT_W-1:0]   r_cnt;
    logic [YC_PHASE_W-1:0] r_phase_inc;
    logic                  r_std_pal;
    logic                  r_pal_flip;
    logic                  r_accum_clr;
    logic [YC_LINE_W-1:0]  r_line_num;

    yc_edge_detect u_hs_edge (
        .i_clk  (i_clk),
        .i_sig  (i_hsync),
        .o_dly  (w_hs_dly_unused),
        .o_rise (w_hs_rise),
        .o_fall (w_hs_fall)
    );

    yc_edge_detect u_vs_edge (
        .i_clk  (i_clk),
        .i_sig  (i_vsync),
        .o_dly  (w_vs_dly),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall_unused)
    );

    assign w_phase_sel = i_pal_en ? i_phase_inc_pal : i_phase_inc_ntsc;

    // Horizontal timing: cycle counter from hsync fall and the line-phase FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SYNC;
            r_cnt   <= {YC_CNT_W{1'b0}};
        end else begin
            r_cnt <= w_hs_fall ? {YC_CNT_W{1'b0}} : yc_cnt_inc(r_cnt);
            if (w_hs_rise) begin
                r_state <= SYNC;
            end else begin
                case (r_state)
                    SYNC:    if (w_hs_fall)              r_state <= BACK;
                    BACK:    if (r_cnt == C_BURST_ON)    r_state <= BURST;
                    BURST:   if (r_cnt == C_BURST_OFF)   r_state <= GAP;
                    GAP:     if (r_cnt == C_ACT_ON)      r_state <= ACTIVE;
                    ACTIVE:  r_state <= ACTIVE;
                    default: r_state <= SYNC;
                endcase
            end
        end
    end

    // Field latch and per-line bookkeeping; field start outranks a coincident line step
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_std_pal   <= i_pal_en;
            r_phase_inc <= w_phase_sel;
            r_accum_clr <= 1'b0;
            r_line_num  <= {YC_LINE_W{1'b0}};
            r_pal_flip  <= 1'b0;
        end else begin
            r_accum_clr <= w_vs_rise;
            if (w_vs_rise) begin
                r_std_pal   <= i_pal_en;
                r_phase_inc <= w_phase_sel;
                r_line_num  <= {YC_LINE_W{1'b0}};
                r_pal_flip  <= 1'b0;
            end else if (w_hs_rise) begin
                r_line_num  <= yc_line_inc(r_line_num);
                r_pal_flip  <= r_std_pal ? ~r_pal_flip : 1'b0;
            end
        end
    end

    // Gates come straight off the state register so they align with the counter
    assign o_burst_gate  = (r_state == BURST)  & ~w_vs_dly;
    assign o_active_gate = (r_state == ACTIVE) & ~w_vs_dly;
    assign o_phase_inc   = r_phase_inc;
    assign o_std_pal     = r_std_pal;
    assign o_pal_flip    = r_pal_flip;
    assign o_accum_clr   = r_accum_clr;
    assign o_line_num    = r_line_num;

endmodule

// File: tb/tb_yc_line_sequencer.sv
// Self-checking bench for yc_line_sequencer: directed line/field scenarios plus randomized lines
// compared every cycle against a window/event reference model.
module tb_yc_line_sequencer;

    localparam logic [39:0] NTSC_INC = 40'd36650387593;
    localparam logic [39:0] PAL_INC  = 40'd45397121234;
    localparam int BS = 60;
    localparam int BL = 100;
    localparam int AS = 240;

    logic        clk = 1'b0;
    logic        reset;
    logic        pal_en;
    logic [39:0] inc_ntsc;
    logic [39:0] inc_pal;
    logic        hsync;
    logic        vsync;
    logic [39:0] phase_inc;
    logic        std_pal;
    logic        burst_gate;
    logic        active_gate;
    logic        pal_flip;
    logic        accum_clr;
    logic [9:0]  line_num;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_burst, n_active, n_clr;

    // reference model state
    bit          m_h_prev = 1'b0;
    bit          m_v_prev = 1'b0;
    bit          m_in_line;
    int          m_since;
    int          m_line;
    bit          m_flip;
    bit          m_clr;
    bit          m_pal;
    logic [39:0] m_inc;

    yc_line_sequencer dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_pal_en         (pal_en),
        .i_phase_inc_ntsc (inc_ntsc),
        .i_phase_inc_pal  (inc_pal),
        .i_hsync          (hsync),
        .i_vsync          (vsync),
        .o_phase_inc      (phase_inc),
        .o_std_pal        (std_pal),
        .o_burst_gate     (burst_gate),
        .o_active_gate    (active_gate),
        .o_pal_flip       (pal_flip),
        .o_accum_clr      (accum_clr),
        .o_line_num       (line_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: advance the model with the inputs seen at the edge, then compare every output
    task automatic step();
        bit hr, hf, vr, e_burst, e_active;
        @(posedge clk);
        hr = hsync && !m_h_prev;
        hf = !hsync && m_h_prev;
        vr = vsync && !m_v_prev;
        m_h_prev = hsync;
        m_v_prev = vsync;
        if (reset) begin
            m_in_line = 1'b0;
            m_since   = 0;
            m_line    = 0;
            m_flip    = 1'b0;
            m_clr     = 1'b0;
            m_pal     = pal_en;
            m_inc     = pal_en ? inc_pal : inc_ntsc;
        end else begin
            if (hf) begin
                m_in_line = 1'b1;
                m_since   = 0;
            end else begin
                m_since++;
            end
            if (hr) m_in_line = 1'b0;
            m_clr = vr;
            if (vr) begin
                m_pal  = pal_en;
                m_inc  = pal_en ? inc_pal : inc_ntsc;
                m_line = 0;
                m_flip = 1'b0;
            end else if (hr) begin
                if (m_line < 1023) m_line++;
                m_flip = m_pal ? !m_flip : 1'b0;
            end
        end
        e_burst  = m_in_line && (m_since >= BS) && (m_since <= BS + BL - 1) && !m_v_prev;
        e_active = m_in_line && (m_since >= AS) && !m_v_prev;
        #1;
        chk("burst_gate",  64'(burst_gate),  64'(e_burst));
        chk("active_gate", 64'(active_gate), 64'(e_active));
        chk("accum_clr",   64'(accum_clr),   64'(m_clr));
        chk("pal_flip",    64'(pal_flip),    64'(m_flip));
        chk("line_num",    64'(line_num),    64'(m_line));
        chk("std_pal",     64'(std_pal),     64'(m_pal));
        chk("phase_inc",   64'(phase_inc),   64'(m_inc));
        if (burst_gate)  n_burst++;
        if (active_gate) n_active++;
        if (accum_clr)   n_clr++;
    endtask

    // one line: vsync updated together with hsync rising, then hsync high/low phases
    task automatic line(input int hi, input int lo, input bit vs);
        n_burst  = 0;
        n_active = 0;
        n_clr    = 0;
        hsync = 1'b1;
        vsync = vs;
        repeat (hi) step();
        hsync = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        reset    = 1'b1;
        pal_en   = 1'b0;
        inc_ntsc = NTSC_INC;
        inc_pal  = PAL_INC;
        hsync    = 1'b0;
        vsync    = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_phase_inc", 64'(phase_inc), 64'(NTSC_INC));
        chk("rst_std_pal",   64'(std_pal),   64'd0);
        chk("rst_line_num",  64'(line_num),  64'd0);
        chk("rst_gates",     64'({burst_gate, active_gate, pal_flip, accum_clr}), 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // default window timing
        line(20, 600, 1'b0);
        chk("burst_cycles",  64'(n_burst),  64'(BL));
        chk("active_cycles", 64'(n_active), 64'(600 - AS));

        // standard change mid-field is deferred to the next field start
        pal_en = 1'b1;
        line(20, 300, 1'b0);
        chk("midfield_std",   64'(std_pal),   64'd0);
        chk("midfield_inc",   64'(phase_inc), 64'(NTSC_INC));
        line(20, 300, 1'b1);
        chk("field_clr_len",  64'(n_clr),     64'd1);
        chk("field_std",      64'(std_pal),   64'd1);
        chk("field_inc",      64'(phase_inc), 64'(PAL_INC));
        chk("vsync_line_gates", 64'(n_burst + n_active), 64'd0);
        chk("field_line0",    64'(line_num),  64'd0);

        // PAL line sequence and coincident field start
        for (int i = 1; i <= 3; i++) begin
            line(20, 300, 1'b0);
            chk("pal_line_num", 64'(line_num), 64'(i));
            chk("pal_flip_seq", 64'(pal_flip), 64'(i % 2));
        end
        line(20, 300, 1'b1);
        chk("coinc_line_num", 64'(line_num), 64'd0);
        chk("coinc_flip",     64'(pal_flip), 64'd0);

        // hsync rises mid-burst at cnt=100
        line(20, 101, 1'b0);
        chk("short_burst_cycles",  64'(n_burst),  64'(101 - BS));
        chk("short_active_cycles", 64'(n_active), 64'd0);
        hsync = 1'b1;
        step();
        chk("short_burst_drop", 64'(burst_gate), 64'd0);

        // reset while active
        line(20, 300, 1'b0);
        chk("pre_reset_active", 64'(active_gate), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_reset_outs", 64'({burst_gate, active_gate, pal_flip, accum_clr}), 64'd0);
        chk("mid_reset_line", 64'(line_num),  64'd0);
        chk("mid_reset_inc",  64'(phase_inc), 64'(PAL_INC));
        reset = 1'b0;

        // line_num saturation and counter saturation on a very long line
        repeat (1030) line(2, 2, 1'b0);
        chk("line_sat", 64'(line_num), 64'd1023);
        line(5, 4300, 1'b0);
        chk("cnt_sat_active", 64'(active_gate), 64'd1);

        // randomized lines, fields, standard/increment changes and occasional resets
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) pal_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) inc_ntsc = {$urandom_range(0, 255), $urandom()};
            if ($urandom_range(0, 3) == 0) inc_pal  = {$urandom_range(0, 255), $urandom()};
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            line($urandom_range(1, 40), $urandom_range(1, 800), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
